// File: rtl/display_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller. A shadow digit bank is
// written over valid/ready and copied to the displayed bank only at a frame wrap.
module display_scan_ctrl #(
    parameter int N_DIG = 4,
    parameter int PRESC = 1000,
    parameter int BLANK = 8,
    localparam int IW = $clog2(N_DIG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [IW-1:0]    wr_addr,
    input  logic [3:0]       wr_data,
    input  logic             commit_req,
    output logic             commit_ack,
    output logic             seg1,
    output logic             seg2,
    output logic             seg3,
    output logic             seg4,
    output logic             seg5,
    output logic             seg6,
    output logic             seg7,
    output logic [N_DIG-1:0] an,
    output logic [IW-1:0]    scan_idx
);
    localparam int CW = $clog2(PRESC);

    typedef enum logic [1:0] {S_OFF, S_BLANK, S_DRIVE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      scan_q, scan_d;
    logic [3:0]         shadow_q [N_DIG];
    logic [3:0]         shadow_d [N_DIG];
    logic [3:0]         active_q [N_DIG];
    logic [3:0]         active_d [N_DIG];
    logic               pending_q, pending_d;
    logic               ack_q, ack_d;
    logic [N_DIG-1:0]   an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               slot_end, wrap, copy;

    // Segment order is {a,b,c,d,e,f,g}.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'b1111110;
            4'h1: glyph = 7'b0110000;
            4'h2: glyph = 7'b1101101;
            4'h3: glyph = 7'b1111001;
            4'h4: glyph = 7'b0110011;
            4'h5: glyph = 7'b1011011;
            4'h6: glyph = 7'b1011111;
            4'h7: glyph = 7'b1110000;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1110011;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b0011111;
            4'hC: glyph = 7'b1001110;
            4'hD: glyph = 7'b0111101;
            4'hE: glyph = 7'b1001111;
            default: glyph = 7'b1000111;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        scan_d    = scan_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        an_d      = '0;
        seg_d     = '0;

        slot_end = (cnt_q == CW'(PRESC - 1));
        wrap     = (state_q != S_OFF) && enable && slot_end && (scan_q == IW'(N_DIG - 1));
        // While off there is no frame to tear, so a pending commit lands at once.
        copy     = pending_q && ((state_q == S_OFF) || wrap);

        if (wr_valid && !pending_q && (int'(wr_addr) < N_DIG))
            shadow_d[wr_addr] = wr_data;

        if (copy) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
            ack_d     = 1'b1;
        end else if (commit_req && !pending_q) begin
            pending_d = 1'b1;
        end

        if (!enable) begin
            state_d = S_OFF;
            cnt_d   = '0;
            scan_d  = '0;
        end else if (state_q == S_OFF) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            scan_d  = '0;
        end else begin
            if (slot_end) begin
                cnt_d  = '0;
                scan_d = (scan_q == IW'(N_DIG - 1)) ? '0 : scan_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            state_d = (cnt_d < CW'(BLANK)) ? S_BLANK : S_DRIVE;
        end

        // Outputs register the next state so they line up with the counter.
        if (state_d == S_DRIVE) begin
            an_d[scan_d] = 1'b1;
            seg_d        = glyph(active_d[scan_d]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_OFF;
            cnt_q     <= '0;
            scan_q    <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            an_q      <= '0;
            seg_q     <= '0;
            for (int i = 0; i < N_DIG; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scan_q    <= scan_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
        end
    end

    assign wr_ready   = ~pending_q;
    assign commit_ack = ack_q;
    assign an         = an_q;
    assign scan_idx   = scan_q;
    assign {seg1, seg2, seg3, seg4, seg5, seg6, seg7} = seg_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: a frame-time model (one running cycle count
// since enable) predicts every output each cycle, plus hand-computed pins.
module tb_display_scan_ctrl;
  localparam int N_DIG = 4;
  localparam int PRESC = 8;
  localparam int BLANK = 2;
  localparam int FRAME = N_DIG * PRESC;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       commit_req = 1'b0;
  logic       commit_ack;
  logic       seg1, seg2, seg3, seg4, seg5, seg6, seg7;
  logic [3:0] an;
  logic [1:0] scan_idx;

  int n_vec = 0;
  int n_fail = 0;

  logic [6:0] glyph_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // model state
  bit m_on, m_pending, m_ack;
  int m_t;
  int m_shadow [N_DIG];
  int m_active [N_DIG];

  display_scan_ctrl #(.N_DIG(N_DIG), .PRESC(PRESC), .BLANK(BLANK)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit_req(commit_req), .commit_ack(commit_ack),
    .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4),
    .seg5(seg5), .seg6(seg6), .seg7(seg7),
    .an(an), .scan_idx(scan_idx)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] segs();
    return {seg1, seg2, seg3, seg4, seg5, seg6, seg7};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_pending = 0; m_ack = 0; m_t = 0;
    for (int i = 0; i < N_DIG; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
  endtask

  // Advance the model by one edge using the current inputs.
  task automatic model_step();
    bit wrap, copy;
    wrap = m_on && enable && ((m_t % FRAME) == FRAME - 1);
    copy = m_pending && (!m_on || wrap);
    if (wr_valid && !m_pending && int'(wr_addr) < N_DIG) m_shadow[wr_addr] = wr_data;
    m_ack = copy;
    if (copy) begin
      for (int i = 0; i < N_DIG; i++) m_active[i] = m_shadow[i];
      m_pending = 0;
    end else if (commit_req) begin
      m_pending = 1;
    end
    m_t  = (enable && m_on) ? m_t + 1 : 0;
    m_on = enable;
  endtask

  task automatic compare();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    int dig;
    dig   = m_on ? (m_t / PRESC) % N_DIG : 0;
    e_an  = '0;
    e_seg = '0;
    if (m_on && (m_t % PRESC) >= BLANK) begin
      e_an[dig] = 1'b1;
      e_seg     = glyph_tab[m_active[dig]];
    end
    chk("an", 32'(an), 32'(e_an));
    chk("segs", 32'(segs()), 32'(e_seg));
    chk("scan_idx", 32'(scan_idx), 32'(dig));
    chk("wr_ready", 32'(wr_ready), 32'(!m_pending));
    chk("commit_ack", 32'(commit_ack), 32'(m_ack));
  endtask

  // One clock: model update from current inputs, edge, then compare #1 later.
  task automatic cycle();
    if (reset) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic write_digit(input int addr, input int data);
    wr_valid = 1'b1;
    wr_addr  = 2'(addr);
    wr_data  = 4'(data);
    cycle();
    wr_valid = 1'b0;
  endtask

  task automatic commit_pulse();
    commit_req = 1'b1;
    cycle();
    commit_req = 1'b0;
  endtask

  task automatic wait_ack(input int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (commit_ack) begin
        got = 1;
        break;
      end
    end
    chk("ack_wait", 32'(got), 32'd1);
  endtask

  initial begin
    int acks;
    bit found;
    model_reset();

    // Reset state, then release with enable=1.
    cycle();
    cycle();
    chk("rst_an", 32'(an), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    reset = 1'b0;
    cycle();
    chk("t1_blank0", 32'(an), 32'd0);
    cycle();
    chk("t1_blank1", 32'(an), 32'd0);
    cycle();
    chk("t1_drive_an", 32'(an), 32'b0001);
    chk("t1_drive_seg", 32'(segs()), 32'b1111110);
    repeat (5) cycle();
    chk("t1_drive_last", 32'(an), 32'b0001);
    cycle();
    chk("t1_slot_blank", 32'(an), 32'd0);
    repeat (2) cycle();
    chk("t1_next_digit", 32'(an), 32'b0010);

    // Write 2,5,7,3 and commit mid-frame; new values appear only after the wrap.
    write_digit(0, 2);
    write_digit(1, 5);
    write_digit(2, 7);
    write_digit(3, 3);
    commit_pulse();
    chk("t2_pending", 32'(wr_ready), 32'd0);
    wait_ack(FRAME + 4);
    repeat (2) cycle();
    chk("t2_d0", 32'({an, segs()}), 32'({4'b0001, 7'b1101101}));
    repeat (PRESC) cycle();
    chk("t2_d1", 32'({an, segs()}), 32'({4'b0010, 7'b1011011}));
    repeat (PRESC) cycle();
    chk("t2_d2", 32'({an, segs()}), 32'({4'b0100, 7'b1110000}));
    repeat (PRESC) cycle();
    chk("t2_d3", 32'({an, segs()}), 32'({4'b1000, 7'b1111001}));

    // Write blocked while pending; repeated commit_req yields one ack.
    commit_pulse();
    wr_valid = 1'b1;
    wr_addr  = 2'd0;
    wr_data  = 4'd9;
    chk("t3_blocked", 32'(wr_ready), 32'd0);
    cycle();
    wr_valid = 1'b0;
    commit_pulse();
    acks = 0;
    for (int i = 0; i < FRAME + 8; i++) begin
      cycle();
      if (commit_ack) acks++;
    end
    chk("t3_single_ack", 32'(acks), 32'd1);
    chk("t3_ready_again", 32'(wr_ready), 32'd1);
    write_digit(0, 9);

    // Disable mid-drive, commit while off, re-enable.
    found = 0;
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      if (an != 0) begin
        found = 1;
        break;
      end
    end
    chk("t4_reach_drive", 32'(found), 32'd1);
    enable = 1'b0;
    cycle();
    chk("t4_off_an", 32'(an), 32'd0);
    write_digit(1, 14);
    commit_pulse();
    chk("t4_no_ack_yet", 32'(commit_ack), 32'd0);
    cycle();
    chk("t4_off_ack", 32'(commit_ack), 32'd1);
    enable = 1'b1;
    cycle();
    chk("t4_restart", 32'({scan_idx, an}), 32'd0);
    repeat (2) cycle();
    chk("t4_d0", 32'({an, segs()}), 32'({4'b0001, 7'b1110011}));
    repeat (PRESC) cycle();
    chk("t4_d1", 32'({an, segs()}), 32'({4'b0010, 7'b1001111}));

    // Async reset while pending and digit 2 is lit.
    commit_pulse();
    found = 0;
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      if (an == 4'b0100) begin
        found = 1;
        break;
      end
    end
    chk("t5_reach_d2", 32'(found), 32'd1);
    chk("t5_pending", 32'(wr_ready), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_an", 32'(an), 32'd0);
    chk("t5_async_ready", 32'(wr_ready), 32'd1);
    model_reset();
    cycle();
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < FRAME + 4; i++) begin
      cycle();
      if (commit_ack) acks++;
    end
    chk("t5_no_ack", 32'(acks), 32'd0);

    // Glyph sweep on digit 0.
    for (int v = 0; v < 16; v++) begin
      write_digit(0, v);
      commit_pulse();
      wait_ack(FRAME + 4);
      repeat (2) cycle();
      chk("t6_glyph", 32'({an, segs()}), 32'({4'b0001, glyph_tab[v]}));
    end
    chk("t6_glyph_F", 32'(segs()), 32'b1000111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller that shares a single seven-segment glyph decoder and segment bus among N_DIG digits. Digit values are written over a valid/ready handshake into a shadow bank. A commit request transfers the shadow bank to the active bank, but only at a frame boundary, so the display never shows a torn frame. Each digit slot starts with a blanking interval to suppress ghosting.

Parameters:
N_DIG, 4, number of digits scanned (2..8); IW = $clog2(N_DIG)
PRESC, 1000, clock cycles per digit slot (PRESC > BLANK)
BLANK, 8, blank cycles at the start of each slot (>= 1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-high
enable  in  1  1 = scan display; 0 = display off
wr_valid  in  1  digit write request
wr_ready  out  1  write accepted when wr_valid & wr_ready
wr_addr  in  IW  digit index to write
wr_data  in  4  hex value for that digit
commit_req  in  1  request shadow-to-active transfer
commit_ack  out  1  one-cycle pulse: transfer done
seg1..seg7  out  1 each  a,b,c,d,e,f,g; active-high
an  out  N_DIG  digit enables, one-hot or zero, active-high
scan_idx  out  IW  digit slot currently scanned

Behaviour:
- Reset (async, while reset=1):
  - shadow and active banks all 0; slot counter 0; scan_idx 0; pending 0.
  - an=0, seg1..seg7=0, commit_ack=0, wr_ready=1.
- Writes: wr_ready = ~pending (combinational from the register).
  - On an accepted write, shadow[wr_addr] <= wr_data at that edge.
  - wr_addr >= N_DIG: write is accepted and discarded.
- Commit:
  - commit_req=1 at an edge with pending=0 sets pending; commit_req while pending is ignored.
  - A write accepted in the same cycle as commit_req is included in the commit.
  - Copy edge = the edge where scan_idx wraps N_DIG-1 -> 0. A commit_req sampled on that same edge waits for the next frame.
  - In OFF, the copy edge is the first edge with pending=1.
  - At the copy edge: active <= shadow, pending <= 0, commit_ack <= 1 for exactly one cycle.
- FSM states:
  - OFF: an=0, segs=0, counter and scan_idx held at 0.
  - BLANK: counter < BLANK; an=0, segs=0.
  - DRIVE: counter >= BLANK; an[scan_idx]=1, segs = glyph(active[scan_idx]).
- Slot counter and transitions:
  - Counter counts 0..PRESC-1 while enable=1.
  - At PRESC-1: counter <= 0, scan_idx <= (scan_idx+1) mod N_DIG.
  - enable 1->0: OFF from the next edge.
  - enable 0->1: BLANK at scan_idx 0, counter 0.
- Outputs are registered; an and segs change only on clock edges. No enabled digit ever overlaps another.
- Glyphs, as seg1..seg7:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1110011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
  - b and d are lowercase.
- Reset mid-operation: everything returns to reset values immediately. A pending commit is dropped with no ack.

Test Plan:
(Use PRESC=8, BLANK=2, N_DIG=4 unless noted.)
1. Reset then release with enable=1 -> an=0000, segs=0000000 for 2 cycles; then an=0001, segs=1111110 for 6 cycles; then 2 blank cycles; then an=0010.
2. Write addr0..3 = 2,5,7,3, then commit_req mid-frame -> display still shows 0s until wrap. commit_ack is one cycle after the wrap edge. Next frame shows an=0001/1101101, 0010/1011011, 0100/1110000, 1000/1111001.
3. commit_req, then wr_valid while pending -> wr_ready=0 and shadow unchanged. After commit_ack, the write is accepted (wr_ready=1). A commit_req repeated while pending produces only one ack.
4. enable=0 mid-DRIVE -> an=0000 next cycle. commit_req in OFF -> ack one cycle after the following edge. enable=1 -> restart at scan_idx 0 with a blank phase.
5. Assert reset with pending=1 and an=0100 -> an=0, commit_ack never pulses, active bank back to 0, wr_ready=1.
6. Glyph sweep: write values 0..F to digit 0 and commit each -> segs match the table above exactly during DRIVE of slot 0.
